// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy formation: march FSM states,
// screen bounds, movement step sizes and formation size.
package enemy_pkg;

  localparam int unsigned POS_W    = 10;
  localparam int unsigned ALIVE_W  = 6;
  localparam int unsigned PERIOD_W = 7;
  localparam int unsigned CLEAR_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARCH = 2'd1,
    CLEAR = 2'd2
  } march_state_e;

  localparam logic [POS_W-1:0]    SCREEN_LEFT  = 10'd8;
  localparam logic [POS_W-1:0]    SCREEN_RIGHT = 10'd631;
  localparam logic [POS_W-1:0]    STEP_PX      = 10'd4;
  localparam logic [POS_W-1:0]    DROP_PX      = 10'd8;
  localparam logic [PERIOD_W-1:0] MIN_PERIOD   = 7'd2;
  localparam logic [ALIVE_W-1:0]  MAX_ALIVE    = 6'd40;
  localparam logic [CLEAR_W-1:0]  CLEAR_FRAMES = 8'd60;

  // Frames between steps: fewer survivors march faster.
  function automatic logic [PERIOD_W-1:0] march_period(
    input logic [PERIOD_W-1:0] min_period,
    input logic [ALIVE_W-1:0]  alive,
    input logic [ALIVE_W-1:0]  max_alive
  );
    logic [ALIVE_W-1:0] clamped;
    clamped = (alive > max_alive) ? max_alive : alive;
    return min_period + PERIOD_W'(clamped);
  endfunction

endpackage

// File: rtl/enemy_step_timer.sv
// Frame-qualified reloadable down-counter; fire_o marks the frame on which
// the count reaches its last tick. Load takes priority over counting.
module enemy_step_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] period_i,
  input  logic         frame_i,
  output logic         fire_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= W'(0);
    end else if (load_i) begin
      count_q <= period_i;
    end else if (frame_i && (count_q != W'(0))) begin
      count_q <= count_q - W'(1);
    end
  end

  assign fire_o = frame_i && (count_q == W'(1));

endmodule

// File: rtl/enemy_march_ctrl.sv
// Formation march controller: paces horizontal steps by alive count, drops
// and reverses at the screen edges, and holds a clear phase between waves.
module enemy_march_ctrl
  import enemy_pkg::*;
#(
  parameter logic [9:0] screen_left_p  = SCREEN_LEFT,
  parameter logic [9:0] screen_right_p = SCREEN_RIGHT,
  parameter logic [9:0] step_px_p      = STEP_PX,
  parameter logic [6:0] min_period_p   = MIN_PERIOD,
  parameter logic [5:0] max_alive_p    = MAX_ALIVE,
  parameter logic [7:0] clear_frames_p = CLEAR_FRAMES
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_i,
  input  logic       start_i,
  input  logic [9:0] left_pos_i,
  input  logic [9:0] right_pos_i,
  input  logic [5:0] alive_count_i,
  input  logic       all_dead_i,
  output logic       step_o,
  output logic       dir_right_o,
  output logic       drop_o,
  output logic       anim_frame_o,
  output logic       wave_clear_o
);

  march_state_e state_q, state_d;

  logic                march_load, march_fire;
  logic                clear_load, clear_fire;
  logic [PERIOD_W-1:0] period;
  logic                at_edge;

  logic step_d, drop_d, dir_d, anim_d, wave_clear_d;

  assign period = march_period(min_period_p, alive_count_i, max_alive_p);

  // Only the edge in the travel direction matters; 11-bit math avoids wrap.
  always_comb begin
    if (dir_right_o) begin
      at_edge = ({1'b0, right_pos_i} + {1'b0, step_px_p}) > {1'b0, screen_right_p};
    end else begin
      at_edge = {1'b0, left_pos_i} < ({1'b0, screen_left_p} + {1'b0, step_px_p});
    end
  end

  enemy_step_timer #(.W(PERIOD_W)) u_march_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (march_load),
    .period_i (period),
    .frame_i  (frame_i && (state_q == MARCH)),
    .fire_o   (march_fire)
  );

  enemy_step_timer #(.W(CLEAR_W)) u_clear_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (clear_load),
    .period_i (clear_frames_p),
    .frame_i  (frame_i && (state_q == CLEAR)),
    .fire_o   (clear_fire)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i)    state_d = MARCH;
      MARCH:   if (all_dead_i) state_d = CLEAR;
      CLEAR:   if (clear_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and timer load controls.
  always_comb begin
    step_d     = 1'b0;
    drop_d     = 1'b0;
    dir_d      = dir_right_o;
    anim_d     = anim_frame_o;
    march_load = 1'b0;
    clear_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          march_load = 1'b1;
          dir_d      = 1'b1;
        end
      end
      MARCH: begin
        if (all_dead_i) begin
          clear_load = 1'b1;
        end else if (march_fire) begin
          march_load = 1'b1;
          anim_d     = ~anim_frame_o;
          if (at_edge) begin
            drop_d = 1'b1;
            dir_d  = ~dir_right_o;
          end else begin
            step_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    wave_clear_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      step_o       <= 1'b0;
      drop_o       <= 1'b0;
      dir_right_o  <= 1'b1;
      anim_frame_o <= 1'b0;
      wave_clear_o <= 1'b0;
    end else begin
      step_o       <= step_d;
      drop_o       <= drop_d;
      dir_right_o  <= dir_d;
      anim_frame_o <= anim_d;
      wave_clear_o <= wave_clear_d;
    end
  end

endmodule
